// File: rtl/imem_boot_loader_pkg.sv
// Shared definitions for the instruction-memory boot loader: FSM states, stream framing and the checksum helper.
// The optional trailing checksum byte is enabled by defining CHECKSUM_EN.
package imem_boot_loader_pkg;

  localparam int WORD           = 32;
  localparam int BYTES_PER_WORD = 4;
  localparam int DEPTH_DEFAULT  = 256;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LEN_HI = 3'd1,
    ST_LEN_LO = 3'd2,
    ST_DATA   = 3'd3,
    ST_WRITE  = 3'd4,
    ST_CHECK  = 3'd5,
    ST_DONE   = 3'd6,
    ST_ERR    = 3'd7
  } bootState_e;

  // Running modulo-256 sum of stream bytes.
  function automatic logic [7:0] sumAdd(input logic [7:0] acc, input logic [7:0] b);
    return 8'(acc + b);
  endfunction

endpackage

// File: rtl/imem_boot_loader_byte_packer.sv
// Big-endian byte-to-word packer for the boot loader; word/wordFull describe the word
// as it stands once the byte currently on byteIn is pushed.
module imem_boot_loader_byte_packer
  import imem_boot_loader_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            clr,
  input  logic            push,
  input  logic [7:0]      byteIn,
  output logic [WORD-1:0] word,
  output logic            wordFull
);

  logic [23:0] shift_r;
  logic [1:0]  byteIdx_r;

  assign word     = {shift_r, byteIn};
  assign wordFull = (byteIdx_r == 2'(BYTES_PER_WORD - 1));

  // Shift in accepted bytes; byteIdx wraps after the fourth so the next word starts cleanly.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      shift_r   <= 24'd0;
      byteIdx_r <= 2'd0;
    end else if (push) begin
      shift_r   <= {shift_r[15:0], byteIn};
      byteIdx_r <= byteIdx_r + 2'd1;
    end else begin
      shift_r   <= shift_r;
      byteIdx_r <= byteIdx_r;
    end
  end

endmodule

// File: rtl/imem_boot_loader.sv
// Boot loader: receives a length-prefixed byte stream, writes words to instruction memory, then releases the CPU.
// Define CHECKSUM_EN to require a trailing byte that makes the data-byte sum 0 mod 256.
module imem_boot_loader
  import imem_boot_loader_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [7:0]      byteIn,
  input  logic            byteValid,
  output logic            byteReady,
  output logic            memWrite,
  output logic [WORD-1:0] memAddr,
  output logic [WORD-1:0] memData,
  output logic            cpuRst,
  output logic            done,
  output logic            error
);

  localparam logic [15:0] DEPTH_W = 16'(DEPTH);

  bootState_e      state_r;
  logic            byteReady_r;
  logic            memWrite_r;
  logic [WORD-1:0] memAddr_r;
  logic [WORD-1:0] memData_r;
  logic            cpuRst_r;
  logic            done_r;
  logic            error_r;
  logic [7:0]      countHi_r;
  logic [15:0]     count_r;
  logic [15:0]     wordIdx_r;
`ifdef CHECKSUM_EN
  logic [7:0]      sum_r;
`endif

  logic            accept_s;
  logic            push_s;
  logic            clr_s;
  logic            wordFull_s;
  logic [WORD-1:0] packWord_s;
  logic [15:0]     lenNext_s;
  logic [15:0]     wordIdxInc_s;

  assign accept_s     = byteValid & byteReady_r;
  assign push_s       = accept_s & (state_r == ST_DATA);
  assign clr_s        = start & (state_r == ST_IDLE);
  assign lenNext_s    = {countHi_r, byteIn};
  assign wordIdxInc_s = wordIdx_r + 16'd1;

  assign byteReady = byteReady_r;
  assign memWrite  = memWrite_r;
  assign memAddr   = memAddr_r;
  assign memData   = memData_r;
  assign cpuRst    = cpuRst_r;
  assign done      = done_r;
  assign error     = error_r;

  imem_boot_loader_byte_packer uPacker (
    .clk      (clk),
    .rst      (rst),
    .clr      (clr_s),
    .push     (push_s),
    .byteIn   (byteIn),
    .word     (packWord_s),
    .wordFull (wordFull_s)
  );

  // Load FSM with counters and registered outputs; memWrite defaults low so it only pulses for one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      byteReady_r <= 1'b0;
      memWrite_r  <= 1'b0;
      memAddr_r   <= 32'd0;
      memData_r   <= 32'd0;
      cpuRst_r    <= 1'b1;
      done_r      <= 1'b0;
      error_r     <= 1'b0;
      countHi_r   <= 8'd0;
      count_r     <= 16'd0;
      wordIdx_r   <= 16'd0;
`ifdef CHECKSUM_EN
      sum_r       <= 8'd0;
`endif
    end else begin
      memWrite_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            state_r     <= ST_LEN_HI;
            byteReady_r <= 1'b1;
            countHi_r   <= 8'd0;
            count_r     <= 16'd0;
            wordIdx_r   <= 16'd0;
`ifdef CHECKSUM_EN
            sum_r       <= 8'd0;
`endif
          end
        end
        ST_LEN_HI: begin
          if (accept_s) begin
            countHi_r <= byteIn;
            state_r   <= ST_LEN_LO;
          end
        end
        ST_LEN_LO: begin
          if (accept_s) begin
            count_r   <= lenNext_s;
            wordIdx_r <= 16'd0;
            if (lenNext_s > DEPTH_W) begin
              state_r     <= ST_ERR;
              byteReady_r <= 1'b0;
              error_r     <= 1'b1;
            end else if (lenNext_s == 16'd0) begin
`ifdef CHECKSUM_EN
              state_r     <= ST_CHECK;
`else
              state_r     <= ST_DONE;
              byteReady_r <= 1'b0;
              done_r      <= 1'b1;
              cpuRst_r    <= 1'b0;
`endif
            end else begin
              state_r <= ST_DATA;
            end
          end
        end
        ST_DATA: begin
          if (accept_s) begin
`ifdef CHECKSUM_EN
            sum_r <= sumAdd(sum_r, byteIn);
`endif
            if (wordFull_s) begin
              state_r     <= ST_WRITE;
              byteReady_r <= 1'b0;
              memWrite_r  <= 1'b1;
              memAddr_r   <= {14'd0, wordIdx_r, 2'b00};
              memData_r   <= packWord_s;
            end
          end
        end
        ST_WRITE: begin
          // wordIdx stops at the last word so it never exceeds DEPTH-1.
          if (wordIdxInc_s == count_r) begin
`ifdef CHECKSUM_EN
            state_r     <= ST_CHECK;
            byteReady_r <= 1'b1;
`else
            state_r     <= ST_DONE;
            done_r      <= 1'b1;
            cpuRst_r    <= 1'b0;
`endif
          end else begin
            state_r     <= ST_DATA;
            byteReady_r <= 1'b1;
            wordIdx_r   <= wordIdxInc_s;
          end
        end
`ifdef CHECKSUM_EN
        ST_CHECK: begin
          if (accept_s) begin
            byteReady_r <= 1'b0;
            if (sumAdd(sum_r, byteIn) == 8'd0) begin
              state_r  <= ST_DONE;
              done_r   <= 1'b1;
              cpuRst_r <= 1'b0;
            end else begin
              state_r <= ST_ERR;
              error_r <= 1'b1;
            end
          end
        end
`endif
        ST_DONE: begin
          byteReady_r <= 1'b0;
        end
        ST_ERR: begin
          byteReady_r <= 1'b0;
          cpuRst_r    <= 1'b1;
        end
        default: begin
          state_r     <= ST_IDLE;
          byteReady_r <= 1'b0;
          cpuRst_r    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Self-checking bench for imem_boot_loader: randomized images against a word-list reference model.
module tb_imem_boot_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  byteIn = 8'd0;
  logic        byteValid = 1'b0;
  logic        byteReady;
  logic        memWrite;
  logic [31:0] memAddr;
  logic [31:0] memData;
  logic        cpuRst;
  logic        done;
  logic        error;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int doneCyc = -1;

  logic [31:0] img[$];
  logic [31:0] wrAddr[$];
  logic [31:0] wrData[$];
  int          wrCyc[$];
  int          accCyc[$];
`ifdef CHECKSUM_EN
  bit          ckBad = 1'b0;
`endif

  imem_boot_loader dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .byteIn    (byteIn),
    .byteValid (byteValid),
    .byteReady (byteReady),
    .memWrite  (memWrite),
    .memAddr   (memAddr),
    .memData   (memData),
    .cpuRst    (cpuRst),
    .done      (done),
    .error     (error)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Record write strobes and the first cycle done is seen; cpuRst must always be the inverse of done.
  always @(negedge clk) begin
    if (!rst) begin
      if (memWrite === 1'b1) begin
        wrAddr.push_back(memAddr);
        wrData.push_back(memData);
        wrCyc.push_back(cyc);
      end
      if (done === 1'b1 && doneCyc < 0) doneCyc = cyc;
      checks++;
      if (cpuRst !== ~done) begin
        errors++;
        $display("FAIL cpuRst_vs_done cyc=%0d cpuRst=%b done=%b", cyc, cpuRst, done);
      end
    end
  end

  task automatic doReset();
    rst = 1'b1; start = 1'b0; byteValid = 1'b0;
    repeat (2) @(negedge clk);
    wrAddr.delete(); wrData.delete(); wrCyc.delete(); accCyc.delete();
    doneCyc = -1;
    rst = 1'b0;
  endtask

  // Offer one byte until accepted; ok/accAt report acceptance and the cycle it took effect.
  task automatic sendByte(input logic [7:0] b, input bit gaps, input bit noise, input int budget,
                          output bit ok, output int accAt);
    ok = 1'b0; accAt = -1;
    for (int t = 0; t < budget; t++) begin
      start = noise && ($urandom_range(0, 3) == 0);
      if (gaps && $urandom_range(0, 1) == 1) begin
        byteValid = 1'b0;
      end else begin
        byteValid = 1'b1;
        byteIn = b;
        ok = (byteReady === 1'b1);
      end
      @(negedge clk);
      if (ok) begin
        accAt = cyc;
        break;
      end
    end
    byteValid = 1'b0;
    start = 1'b0;
  endtask

  task automatic loadImage(input bit gaps, input bit noise, output bit allOk, output int lastAcc);
    logic [15:0] n16;
    logic [7:0]  sum;
    logic [7:0]  b;
    bit ok;
    int at;
    allOk = 1'b1; sum = 8'd0; accCyc.delete();
    n16 = 16'(img.size());
    start = 1'b1; @(negedge clk); start = 1'b0;
    sendByte(n16[15:8], gaps, noise, 64, ok, at); allOk &= ok;
    sendByte(n16[7:0], gaps, noise, 64, ok, at); allOk &= ok; lastAcc = at;
    foreach (img[i]) begin
      for (int k = 3; k >= 0; k--) begin
        b = img[i][8*k +: 8];
        sum = 8'(sum + b);
        sendByte(b, gaps, noise, 64, ok, at);
        allOk &= ok; accCyc.push_back(at); lastAcc = at;
      end
    end
`ifdef CHECKSUM_EN
    b = 8'(8'd0 - sum);
    if (ckBad) b = 8'(b + 8'd1);
    sendByte(b, gaps, noise, 64, ok, at); allOk &= ok; lastAcc = at;
`endif
  endtask

  task automatic test_reset();
    doReset();
    checks++; if (cpuRst !== 1'b1)    begin errors++; $display("FAIL reset_cpuRst got=%b exp=1", cpuRst); end
    checks++; if (byteReady !== 1'b0) begin errors++; $display("FAIL reset_byteReady got=%b exp=0", byteReady); end
    checks++; if (memWrite !== 1'b0)  begin errors++; $display("FAIL reset_memWrite got=%b exp=0", memWrite); end
    checks++; if (memAddr !== 32'd0)  begin errors++; $display("FAIL reset_memAddr got=%h exp=0", memAddr); end
    checks++; if (memData !== 32'd0)  begin errors++; $display("FAIL reset_memData got=%h exp=0", memData); end
    checks++; if (done !== 1'b0)      begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
    checks++; if (error !== 1'b0)     begin errors++; $display("FAIL reset_error got=%b exp=0", error); end
  endtask

  // Load an image (case 1 when fixed1, random words otherwise) and compare against the word list.
  task automatic test_load(input string name, input int n, input bit fixed1, input bit gaps, input bit noise);
    bit allOk;
    int lastAcc;
    int expDone;
    img.delete();
    if (fixed1) begin
      img.push_back(32'h20080005);
      img.push_back(32'h8C090004);
    end else begin
      for (int i = 0; i < n; i++) img.push_back($urandom);
    end
    doReset();
    loadImage(gaps, noise, allOk, lastAcc);
    repeat (3) @(negedge clk);
`ifdef CHECKSUM_EN
    expDone = lastAcc;
`else
    expDone = (img.size() == 0) ? lastAcc : lastAcc + 1;
`endif
    checks++; if (allOk !== 1'b1) begin errors++; $display("FAIL %s_accept got=%b exp=1", name, allOk); end
    checks++;
    if (wrAddr.size() != img.size()) begin
      errors++; $display("FAIL %s_strobes got=%0d exp=%0d", name, wrAddr.size(), img.size());
    end else begin
      foreach (img[i]) begin
        checks++;
        if (wrAddr[i] !== 32'(i * 4)) begin errors++; $display("FAIL %s_addr[%0d] got=%h exp=%h", name, i, wrAddr[i], 32'(i * 4)); end
        checks++;
        if (wrData[i] !== img[i]) begin errors++; $display("FAIL %s_data[%0d] got=%h exp=%h", name, i, wrData[i], img[i]); end
        checks++;
        if (accCyc.size() > 4*i+3 && wrCyc[i] != accCyc[4*i+3]) begin
          errors++; $display("FAIL %s_latency[%0d] got=%0d exp=%0d", name, i, wrCyc[i], accCyc[4*i+3]);
        end
      end
    end
    checks++; if (doneCyc != expDone) begin errors++; $display("FAIL %s_doneCycle got=%0d exp=%0d", name, doneCyc, expDone); end
    checks++; if (done !== 1'b1)      begin errors++; $display("FAIL %s_done got=%b exp=1", name, done); end
    checks++; if (cpuRst !== 1'b0)    begin errors++; $display("FAIL %s_cpuRst got=%b exp=0", name, cpuRst); end
    checks++; if (error !== 1'b0)     begin errors++; $display("FAIL %s_error got=%b exp=0", name, error); end
    checks++; if (byteReady !== 1'b0) begin errors++; $display("FAIL %s_byteReady got=%b exp=0", name, byteReady); end
  endtask

  task automatic test_oversize();
    bit ok;
    int at;
    doReset();
    start = 1'b1; @(negedge clk); start = 1'b0;
    sendByte(8'h01, 1'b0, 1'b0, 16, ok, at);
    sendByte(8'h01, 1'b0, 1'b0, 16, ok, at);
    checks++; if (error !== 1'b1)     begin errors++; $display("FAIL oversize_error got=%b exp=1", error); end
    checks++; if (cpuRst !== 1'b1)    begin errors++; $display("FAIL oversize_cpuRst got=%b exp=1", cpuRst); end
    checks++; if (byteReady !== 1'b0) begin errors++; $display("FAIL oversize_byteReady got=%b exp=0", byteReady); end
    sendByte(8'hAA, 1'b0, 1'b1, 8, ok, at);
    checks++; if (ok !== 1'b0) begin errors++; $display("FAIL oversize_accept got=%b exp=0", ok); end
    checks++; if (wrAddr.size() != 0) begin errors++; $display("FAIL oversize_strobes got=%0d exp=0", wrAddr.size()); end
    checks++; if (done !== 1'b0 || error !== 1'b1) begin errors++; $display("FAIL oversize_sticky done=%b error=%b exp done=0 error=1", done, error); end
  endtask

  task automatic test_reset_midload();
    bit ok;
    int at;
    doReset();
    start = 1'b1; @(negedge clk); start = 1'b0;
    sendByte(8'h00, 1'b0, 1'b0, 16, ok, at);
    sendByte(8'h02, 1'b0, 1'b0, 16, ok, at);
    sendByte(8'h20, 1'b0, 1'b0, 16, ok, at);
    sendByte(8'h08, 1'b0, 1'b0, 16, ok, at);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (cpuRst !== 1'b1 || byteReady !== 1'b0 || memWrite !== 1'b0 || memAddr !== 32'd0 ||
        memData !== 32'd0 || done !== 1'b0 || error !== 1'b0) begin
      errors++;
      $display("FAIL midreset_outputs got cpuRst=%b rdy=%b wr=%b addr=%h data=%h done=%b err=%b exp 1 0 0 0 0 0 0",
               cpuRst, byteReady, memWrite, memAddr, memData, done, error);
    end
    test_load("after_midreset", 2, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_start_in_done();
    int nWr;
    test_load("pre_done_start", 2, 1'b1, 1'b0, 1'b0);
    nWr = wrAddr.size();
    start = 1'b1; @(negedge clk); start = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (done !== 1'b1)      begin errors++; $display("FAIL done_start_done got=%b exp=1", done); end
    checks++; if (byteReady !== 1'b0) begin errors++; $display("FAIL done_start_byteReady got=%b exp=0", byteReady); end
    checks++; if (wrAddr.size() != nWr) begin errors++; $display("FAIL done_start_strobes got=%0d exp=%0d", wrAddr.size(), nWr); end
  endtask

`ifdef CHECKSUM_EN
  task automatic test_checksum_bad();
    bit allOk;
    int lastAcc;
    img.delete();
    img.push_back(32'h20080005);
    img.push_back(32'h8C090004);
    doReset();
    ckBad = 1'b1;
    loadImage(1'b0, 1'b0, allOk, lastAcc);
    ckBad = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (error !== 1'b1)  begin errors++; $display("FAIL cksum_bad_error got=%b exp=1", error); end
    checks++; if (cpuRst !== 1'b1) begin errors++; $display("FAIL cksum_bad_cpuRst got=%b exp=1", cpuRst); end
    checks++; if (done !== 1'b0)   begin errors++; $display("FAIL cksum_bad_done got=%b exp=0", done); end
  endtask
`endif

  initial begin
    test_reset();
    test_load("case1", 2, 1'b1, 1'b0, 1'b0);
    test_load("empty", 0, 1'b0, 1'b0, 1'b0);
    test_oversize();
    test_load("case1_gaps", 2, 1'b1, 1'b1, 1'b0);
    test_reset_midload();
    test_start_in_done();
    for (int r = 0; r < 6; r++) begin
      test_load("random", int'($urandom_range(1, 9)), 1'b0, 1'b1, 1'b1);
    end
    test_load("full_depth", 256, 1'b0, 1'b0, 1'b0);
`ifdef CHECKSUM_EN
    test_checksum_bad();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
